// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: FSM state encoding and counter sizing helper.
package pll_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4,
    FAULT     = 3'd5
  } pll_state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// Two-flop synchronizer for the asynchronous PLL lock indication; clears to 0 on reset.
module pll_sup_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, releases the system reset and tracks losses.
// Optional retry limit (FAULT state, fault output) is enabled by defining PLL_SUP_RETRY_LIMIT_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 36,
  parameter int LOCK_TIMEOUT_CYC = 360000,
  parameter int STABLE_CYC       = 3600,
  parameter int LOSS_CNT_W       = 8,
  parameter int MAX_RETRY        = 4
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output logic [STATE_W-1:0]    state,
  output logic                  fault
);

  localparam int PULSE_W = cnt_width(RST_PULSE_CYC);
  localparam int WAIT_W  = cnt_width(LOCK_TIMEOUT_CYC);
  localparam int STAB_W  = cnt_width(STABLE_CYC);

  localparam logic [PULSE_W-1:0]    PULSE_LAST = PULSE_W'(RST_PULSE_CYC - 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [STAB_W-1:0]     STAB_LAST  = STAB_W'(STABLE_CYC - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX   = '1;

  if (RST_PULSE_CYC < 1 || LOCK_TIMEOUT_CYC < 1 || STABLE_CYC < 1 ||
      LOSS_CNT_W < 1 || MAX_RETRY < 1) begin : g_bad_params
    $error("pll_lock_supervisor: parameter out of range");
  end

  logic                  lk;
  pll_state_t            state_reg, state_next;
  logic [PULSE_W-1:0]    pulse_cnt_reg, pulse_cnt_next;
  logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic [STAB_W-1:0]     stab_cnt_reg, stab_cnt_next;
  logic [LOSS_CNT_W-1:0] loss_cnt_reg, loss_cnt_next;
  logic                  pll_rst_reg, sys_rst_reg, ready_reg;

  pll_sup_sync2 u_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  logic [RETRY_W-1:0] retry_cnt_reg, retry_cnt_next;
  logic               retry_last;
  logic               timeout;
  logic               fault_reg;

  assign retry_last = (retry_cnt_reg == RETRY_W'(MAX_RETRY - 1));
  assign timeout    = (state_reg == WAIT_LOCK) && !relock_req && !lk && (wait_cnt_reg == WAIT_LAST);

  // Retries are only "consecutive" timeouts: a good lock or a forced relock restarts the tally.
  always_comb begin
    retry_cnt_next = retry_cnt_reg;
    if (state_reg == RUN || (relock_req && state_reg != RESET_PLL)) begin
      retry_cnt_next = '0;
    end else if (timeout) begin
      retry_cnt_next = retry_cnt_reg + RETRY_W'(1);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      retry_cnt_reg <= '0;
      fault_reg     <= 1'b0;
    end else begin
      retry_cnt_reg <= retry_cnt_next;
      fault_reg     <= (state_next == FAULT);
    end
  end

  assign fault = fault_reg;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RESET_PLL: begin
        // The reset pulse always runs to completion; relock_req is not honoured here.
        if (pulse_cnt_reg == PULSE_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (relock_req) begin
          state_next = RESET_PLL;
        end else if (lk) begin
          state_next = STABILIZE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
`ifdef PLL_SUP_RETRY_LIMIT_EN
          state_next = retry_last ? FAULT : RESET_PLL;
`else
          state_next = RESET_PLL;
`endif
        end
      end
      STABILIZE: begin
        if (relock_req)                   state_next = RESET_PLL;
        else if (!lk)                     state_next = WAIT_LOCK;
        else if (stab_cnt_reg == STAB_LAST) state_next = RUN;
      end
      RUN: begin
        if (relock_req) state_next = RESET_PLL;
        else if (!lk)   state_next = LOST;
      end
      LOST: begin
        // The PLL relocks on its own after a run-time loss, so no reset pulse.
        state_next = relock_req ? RESET_PLL : WAIT_LOCK;
      end
`ifdef PLL_SUP_RETRY_LIMIT_EN
      FAULT: begin
        if (relock_req) state_next = RESET_PLL;
      end
`endif
      default: state_next = RESET_PLL;
    endcase
  end

  // Each timer counts cycles spent in its own state and restarts on any entry.
  always_comb begin
    pulse_cnt_next = '0;
    wait_cnt_next  = '0;
    stab_cnt_next  = '0;
    loss_cnt_next  = loss_cnt_reg;
    if (state_reg == RESET_PLL && state_next == RESET_PLL) pulse_cnt_next = pulse_cnt_reg + PULSE_W'(1);
    if (state_reg == WAIT_LOCK && state_next == WAIT_LOCK) wait_cnt_next  = wait_cnt_reg + WAIT_W'(1);
    if (state_reg == STABILIZE && state_next == STABILIZE) stab_cnt_next  = stab_cnt_reg + STAB_W'(1);
    if (state_reg == RUN && state_next == LOST && loss_cnt_reg != LOSS_MAX) begin
      loss_cnt_next = loss_cnt_reg + LOSS_CNT_W'(1);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg     <= RESET_PLL;
      pulse_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      stab_cnt_reg  <= '0;
      loss_cnt_reg  <= '0;
      pll_rst_reg   <= 1'b1;
      sys_rst_reg   <= 1'b1;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pulse_cnt_reg <= pulse_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      stab_cnt_reg  <= stab_cnt_next;
      loss_cnt_reg  <= loss_cnt_next;
      // Outputs are registered from the next state so they change on the same edge as state.
      pll_rst_reg   <= (state_next == RESET_PLL) || (state_next == FAULT);
      sys_rst_reg   <= (state_next != RUN);
      ready_reg     <= (state_next == RUN);
    end
  end

  assign pll_rst  = pll_rst_reg;
  assign sys_rst  = sys_rst_reg;
  assign ready    = ready_reg;
  assign loss_cnt = loss_cnt_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: a cycle-level reference model pushes expected outputs, a monitor pops and compares.
module tb_pll_lock_supervisor;

  localparam int RST_PULSE = 4;
  localparam int TIMEOUT   = 50;
  localparam int STABLE    = 10;
  localparam int LOSS_W    = 8;
  localparam int MAXR      = 2;

  localparam int S_RST   = 0;
  localparam int S_WAIT  = 1;
  localparam int S_STAB  = 2;
  localparam int S_RUN   = 3;
  localparam int S_LOST  = 4;
  localparam int S_FAULT = 5;

`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  typedef struct packed {
    logic              pll_rst;
    logic              sys_rst;
    logic              ready;
    logic              fault;
    logic [LOSS_W-1:0] loss;
    logic [2:0]        state;
  } obs_t;

  logic              refclk;
  logic              rst;
  logic              pll_locked;
  logic              relock_req;
  logic              pll_rst;
  logic              sys_rst;
  logic              ready;
  logic [LOSS_W-1:0] loss_cnt;
  logic [2:0]        state;
  logic              fault;

  pll_lock_supervisor #(
    .RST_PULSE_CYC    (RST_PULSE),
    .LOCK_TIMEOUT_CYC (TIMEOUT),
    .STABLE_CYC       (STABLE),
    .LOSS_CNT_W       (LOSS_W),
    .MAX_RETRY        (MAXR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .loss_cnt   (loss_cnt),
    .state      (state),
    .fault      (fault)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   bound_err = 0;
  bit   done = 1'b0;

  // Reference model: lk is pll_locked delayed two cycles; age is cycles already spent in the current mode.
  int m_state = S_RST;
  int m_age   = 0;
  int m_retry = 0;
  int m_loss  = 0;
  bit m_s1    = 1'b0;
  bit m_s2    = 1'b0;

  task automatic model_step(input bit r, input bit q, input bit l);
    bit lk;
    int nxt;
    lk  = m_s2;
    nxt = m_state;
    if (r) begin
      m_state = S_RST; m_age = 0; m_retry = 0; m_loss = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
      return;
    end
    if (q && m_state != S_RST) begin
      nxt = S_RST;
      m_retry = 0;
    end else begin
      case (m_state)
        S_RST:  if (m_age + 1 >= RST_PULSE) nxt = S_WAIT;
        S_WAIT: begin
          if (lk) nxt = S_STAB;
          else if (m_age + 1 >= TIMEOUT) begin
            m_retry = m_retry + 1;
            nxt = (LIMIT && m_retry >= MAXR) ? S_FAULT : S_RST;
          end
        end
        S_STAB: begin
          if (!lk) nxt = S_WAIT;
          else if (m_age + 1 >= STABLE) nxt = S_RUN;
        end
        S_RUN: begin
          m_retry = 0;
          if (!lk) nxt = S_LOST;
        end
        S_LOST:  nxt = S_WAIT;
        default: nxt = S_FAULT;
      endcase
    end
    if (m_state == S_RUN && nxt == S_LOST && m_loss < (1 << LOSS_W) - 1) m_loss = m_loss + 1;
    m_age   = (nxt == m_state) ? m_age + 1 : 0;
    m_state = nxt;
    m_s2 = m_s1;
    m_s1 = l;
  endtask

  function automatic obs_t model_obs();
    obs_t e;
    int   st;
    int   lc;
    st = m_state;
    lc = m_loss;
    e.pll_rst = (st == S_RST) || (st == S_FAULT);
    e.sys_rst = (st != S_RUN);
    e.ready   = (st == S_RUN);
    e.fault   = (st == S_FAULT);
    e.loss    = lc[LOSS_W-1:0];
    e.state   = st[2:0];
    return e;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the coming edge.
  task automatic cycle(input bit r, input bit q, input bit l);
    rst        = r;
    relock_req = q;
    pll_locked = l;
    model_step(r, q, l);
    exp_q.push_back(model_obs());
    @(posedge refclk);
    #1;
  endtask

  task automatic run_until(input int target, input bit l, input int max_cyc);
    int n;
    n = 0;
    while (m_state != target && n < max_cyc) begin
      cycle(1'b0, 1'b0, l);
      n++;
    end
    if (m_state != target) begin
      bound_err++;
      $display("FAIL wait_for_state actual=%0d required=%0d after %0d cycles", m_state, target, n);
    end
  endtask

  // Monitor: one comparison per registered output update.
  initial begin
    obs_t e;
    obs_t a;
    int   cyc;
    logic [2:0] last_state;
    cyc = 0;
    last_state = 3'd7;
    forever begin
      @(negedge refclk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{pll_rst: pll_rst, sys_rst: sys_rst, ready: ready, fault: fault,
              loss: loss_cnt, state: state};
        checks++;
        if (a !== e) begin
          errors++;
          if (errors <= 20)
            $display("FAIL outputs cycle %0d actual pll_rst=%b sys_rst=%b ready=%b fault=%b loss=%0d state=%0d required pll_rst=%b sys_rst=%b ready=%b fault=%b loss=%0d state=%0d",
                     cyc, a.pll_rst, a.sys_rst, a.ready, a.fault, a.loss, a.state,
                     e.pll_rst, e.sys_rst, e.ready, e.fault, e.loss, e.state);
        end
        if (e.state != last_state)
          $display("cycle %0d: state %0d pll_rst=%b sys_rst=%b ready=%b fault=%b loss=%0d",
                   cyc, e.state, e.pll_rst, e.sys_rst, e.ready, e.fault, e.loss);
        last_state = e.state;
      end else if (done) begin
        checks++;
        if (bound_err != 0) begin
          errors++;
          $display("FAIL bounded_waits actual=%0d required=0", bound_err);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (cyc > 90000) begin
        errors++;
        $display("FAIL watchdog actual=%0d cycles required<=90000", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  // Stimulus
  initial begin
    int hold;
    bit lv;
    rst = 1'b1; relock_req = 1'b0; pll_locked = 1'b0;
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // Bring-up: lock arrives 20 cycles after reset release.
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    run_until(S_RUN, 1'b1, 40);
    repeat (5) cycle(1'b0, 1'b0, 1'b1);

    // One-cycle glitch part-way through stabilization.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    run_until(S_STAB, 1'b1, 100);
    repeat (4) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    run_until(S_RUN, 1'b1, 60);

    // Run-time losses until the counter saturates.
    repeat (300) begin
      repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, 1'b0);
      run_until(S_RUN, 1'b1, 60);
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 1'b1);
    end

    // Lock never returns: repeated timeouts (FAULT when the retry limit is built in).
    repeat (200) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    run_until(S_RUN, 1'b1, 200);

    // Forced relock in RUN, then relock coinciding with a synchronized lock drop.
    cycle(1'b0, 1'b1, 1'b1);
    run_until(S_RUN, 1'b1, 100);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    run_until(S_RUN, 1'b1, 100);

    // Reset in the middle of stabilization, then a fresh bring-up.
    cycle(1'b0, 1'b1, 1'b1);
    run_until(S_STAB, 1'b1, 100);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0, 1'b0);
    run_until(S_RUN, 1'b1, 40);

    // Random lock behaviour with occasional relock requests and resets.
    hold = 0;
    lv   = 1'b0;
    repeat (4000) begin
      if (hold == 0) begin
        lv   = ~lv;
        hold = lv ? int'($urandom_range(5, 120)) : int'($urandom_range(1, 70));
      end
      hold--;
      cycle(($urandom_range(0, 1499) == 0), ($urandom_range(0, 149) == 0), lv);
    end
    done = 1'b1;
  end

endmodule
